// File: rtl/melody_seq.sv
// melody_seq: plays a fixed 16-entry song as timed note / gap segments.
// Each entry drives the tone divider for its note length minus a short
// silent gap. Playback ends at the end-marker code or at the end of the
// table, and optionally loops back to entry 0.
module melody_seq #(
  parameter int TICK_DIV   = 1000,
  parameter int UNIT_TICKS = 125,
  parameter int GAP_TICKS  = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        loop,
  output logic [11:0] half_period,
  output logic        tone_en,
  output logic [3:0]  note_idx,
  output logic        busy,
  output logic        done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW = $clog2(8 * UNIT_TICKS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_TICKS - 1);
  localparam logic [3:0]    END_CODE   = 4'hF;

  typedef enum logic [1:0] {IDLE, PLAY, GAP, DONE} state_t;

  state_t          state_reg;
  logic [PW-1:0]   presc_reg;
  logic [TW-1:0]   tick_reg;

  // Note code of each song entry.
  function automatic logic [3:0] song_code(input logic [3:0] a);
    case (a)
      4'd0, 4'd1:   song_code = 4'd1;
      4'd2, 4'd3:   song_code = 4'd8;
      4'd4, 4'd5:   song_code = 4'd10;
      4'd6:         song_code = 4'd8;
      4'd7, 4'd8:   song_code = 4'd6;
      4'd9, 4'd10:  song_code = 4'd5;
      4'd11, 4'd12: song_code = 4'd3;
      4'd13:        song_code = 4'd1;
      default:      song_code = END_CODE;
    endcase
  endfunction

  // Duration field of each song entry (length is dur+1 units).
  function automatic logic [2:0] song_dur(input logic [3:0] a);
    case (a)
      4'd6, 4'd13: song_dur = 3'd1;
      default:     song_dur = 3'd0;
    endcase
  endfunction

  // Half-period of the tone divider for each note code; rests map to 0.
  function automatic logic [11:0] note_hp(input logic [3:0] code);
    case (code)
      4'd1:    note_hp = 12'd1911;
      4'd2:    note_hp = 12'd1804;
      4'd3:    note_hp = 12'd1703;
      4'd4:    note_hp = 12'd1607;
      4'd5:    note_hp = 12'd1517;
      4'd6:    note_hp = 12'd1432;
      4'd7:    note_hp = 12'd1351;
      4'd8:    note_hp = 12'd1275;
      4'd9:    note_hp = 12'd1204;
      4'd10:   note_hp = 12'd1136;
      4'd11:   note_hp = 12'd1072;
      4'd12:   note_hp = 12'd1012;
      4'd13:   note_hp = 12'd955;
      default: note_hp = 12'd0;
    endcase
  endfunction

  function automatic logic is_tone(input logic [3:0] code);
    is_tone = (code != 4'd0) && (code != 4'd14) && (code != END_CODE);
  endfunction

  logic [2:0]    cur_dur;
  logic [TW-1:0] play_last;
  logic          tick_end;
  logic [3:0]    next_idx;
  logic          song_end;
  logic [3:0]    tgt_idx;
  logic [3:0]    tgt_code;
  logic [3:0]    first_code;

  // Segment end points and the entry that follows the current gap.
  always_comb begin
    cur_dur    = song_dur(note_idx);
    play_last  = TW'((int'(cur_dur) + 1) * UNIT_TICKS - GAP_TICKS - 1);
    tick_end   = (presc_reg == PRESC_LAST);
    next_idx   = note_idx + 4'd1;
    song_end   = (note_idx == 4'd15) || (song_code(next_idx) == END_CODE);
    tgt_idx    = song_end ? 4'd0 : next_idx;
    tgt_code   = song_code(tgt_idx);
    first_code = song_code(4'd0);
  end

  // Sequencer state, timing counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      presc_reg   <= '0;
      tick_reg    <= '0;
      half_period <= '0;
      tone_en     <= 1'b0;
      note_idx    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (stop) begin
      state_reg   <= IDLE;
      presc_reg   <= '0;
      tick_reg    <= '0;
      half_period <= '0;
      tone_en     <= 1'b0;
      note_idx    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            presc_reg <= '0;
            tick_reg  <= '0;
            note_idx  <= '0;
            if (first_code == END_CODE) begin
              state_reg <= DONE;
              done      <= 1'b1;
            end else begin
              state_reg   <= PLAY;
              half_period <= note_hp(first_code);
              tone_en     <= is_tone(first_code);
              busy        <= 1'b1;
            end
          end
        end
        PLAY: begin
          if (tick_end && tick_reg == play_last) begin
            state_reg <= GAP;
            tone_en   <= 1'b0;
            presc_reg <= '0;
            tick_reg  <= '0;
          end else if (tick_end) begin
            presc_reg <= '0;
            tick_reg  <= tick_reg + 1'b1;
          end else begin
            presc_reg <= presc_reg + 1'b1;
          end
        end
        GAP: begin
          if (tick_end && tick_reg == GAP_LAST) begin
            presc_reg <= '0;
            tick_reg  <= '0;
            if ((song_end && !loop) || tgt_code == END_CODE) begin
              // Natural end: silence everything and pulse done once.
              state_reg   <= DONE;
              half_period <= '0;
              note_idx    <= '0;
              busy        <= 1'b0;
              done        <= 1'b1;
            end else begin
              state_reg   <= PLAY;
              note_idx    <= tgt_idx;
              half_period <= note_hp(tgt_code);
              tone_en     <= is_tone(tgt_code);
            end
          end else if (tick_end) begin
            presc_reg <= '0;
            tick_reg  <= tick_reg + 1'b1;
          end else begin
            presc_reg <= presc_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_melody_seq.sv
// tb_melody_seq: randomized playback runs against a segment-level model.
// The model turns the song into a list of constant-output segments with
// their lengths in cycles; a monitor splits the DUT outputs into segments
// and compares each one against the queue.
module tb_melody_seq;

  localparam int TD = 4;
  localparam int UT = 3;
  localparam int GT = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic [11:0] half_period;
  logic        tone_en;
  logic [3:0]  note_idx;
  logic        busy;
  logic        done;

  melody_seq #(.TICK_DIV(TD), .UNIT_TICKS(UT), .GAP_TICKS(GT)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
    .half_period(half_period), .tone_en(tone_en), .note_idx(note_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Song and note table as written in the requirements.
  int song_code [16] = '{1, 1, 8, 8, 10, 10, 8, 6, 6, 5, 5, 3, 3, 1, 15, 15};
  int song_dur  [16] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0};
  int hp_tab    [16] = '{0, 1911, 1804, 1703, 1607, 1517, 1432, 1351, 1275,
                         1204, 1136, 1072, 1012, 955, 0, 0};

  typedef struct {
    logic [18:0] v;
    int          len;
  } seg_t;

  seg_t exp_q[$];
  int   model_rem;

  function automatic string fmt(input logic [18:0] v);
    return $sformatf("done=%0d busy=%0d tone=%0d idx=%0d hp=%0d",
                     v[18], v[17], v[16], v[15:12], v[11:0]);
  endfunction

  function automatic logic [18:0] pack(input int dn, input int bz, input int tn,
                                       input int idx, input int hp);
    return {dn[0], bz[0], tn[0], idx[3:0], hp[11:0]};
  endfunction

  task automatic push_seg(input logic [18:0] v, input int len);
    seg_t s;
    if (len < 0) begin
      s.v = v; s.len = -1; exp_q.push_back(s);
    end else if (model_rem > 0) begin
      s.v = v;
      s.len = (len < model_rem) ? len : model_rem;
      model_rem -= s.len;
      exp_q.push_back(s);
    end
  endtask

  // Expected segments for one run truncated after k cycles; total is the
  // number of cycles from the first PLAY cycle to the done pulse.
  task automatic model_run(input bit lp, input int k, output int total);
    int idx, code, plen;
    bit fin;
    idx = 0; fin = 0; total = 0;
    model_rem = k;
    while (!fin && model_rem > 0) begin
      if (idx == 16 || song_code[idx] == 15) begin
        if (lp && idx != 0) idx = 0;
        else begin
          push_seg(pack(1, 0, 0, 0, 0), 1);
          fin = 1;
        end
      end
      if (!fin) begin
        code = song_code[idx];
        plen = ((song_dur[idx] + 1) * UT - GT) * TD;
        push_seg(pack(0, 1, (code >= 1 && code <= 13) ? 1 : 0, idx, hp_tab[code]), plen);
        push_seg(pack(0, 1, 0, idx, hp_tab[code]), GT * TD);
        total += plen + GT * TD;
        idx++;
      end
    end
    push_seg(pack(0, 0, 0, 0, 0), -1);
  endtask

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Monitor: cut the output stream into segments and score each one.
  seg_t        open_seg;
  bit          have_open = 0;
  logic [18:0] cur_v = '0;
  int          cur_len = 0;
  int          seg_no = 0;

  always @(negedge clk) begin
    logic [18:0] v;
    v = {done, busy, tone_en, note_idx, half_period};
    if (v !== cur_v) begin
      if (have_open && open_seg.len >= 0) begin
        tests++;
        if (cur_len != open_seg.len) begin
          fails++;
          $display("FAIL seg%0d length: got %0d cycles, expected %0d (%s)",
                   seg_no, cur_len, open_seg.len, fmt(cur_v));
        end else
          $display("[TB] seg %0d %s len=%0d", seg_no, fmt(cur_v), cur_len);
      end
      tests++;
      seg_no++;
      if (exp_q.size() == 0) begin
        fails++;
        have_open = 0;
        $display("FAIL seg%0d unexpected: got %s, expected no change", seg_no, fmt(v));
      end else begin
        open_seg = exp_q.pop_front();
        have_open = 1;
        if (v !== open_seg.v) begin
          fails++;
          $display("FAIL seg%0d value: got %s, expected %s", seg_no, fmt(v), fmt(open_seg.v));
        end
      end
      cur_v = v;
      cur_len = 1;
    end else begin
      cur_len++;
    end
  end

  // One playback: k==0 runs to the natural end, otherwise stop (or an
  // asynchronous reset) takes effect at the k-th edge after playback starts.
  task automatic run(input bit lp, input int k, input bit use_rst);
    int total, limit, n;
    @(posedge clk); #1;
    loop = lp; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_run(lp, (k == 0) ? 32'h4000_0000 : k, total);
    limit = (k == 0) ? total : ((lp || k < total) ? k : total);
    n = (k == 0) ? total + 6 : k;
    $display("[TB] run loop=%0d k=%0d reset=%0d", lp, k, use_rst);
    for (int j = 1; j < n; j++) begin
      start = (j < limit) && ($urandom_range(0, 7) == 0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (k != 0) begin
      if (!use_rst) begin
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
      end else begin
        @(posedge clk); #1; #1;
        reset = 1'b1;
        #1;
        check("async_reset_tone_en", int'(tone_en), 0);
        check("async_reset_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_half_period", int'(half_period), 0);
    check("reset_tone_en", int'(tone_en), 0);
    check("reset_note_idx", int'(note_idx), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    repeat (4) @(posedge clk);
    #1 check("idle_without_start", int'(busy), 0);

    run(1'b0, 0, 1'b0);                                  // full song, natural end
    run(1'b1, 260 + $urandom_range(0, 60), 1'b0);        // looping, then stop
    run(1'b0, 48 + $urandom_range(1, 6), 1'b0);          // stop inside entry 4

    // start and stop together while idle: stop wins
    @(posedge clk); #1;
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("start_with_stop_busy", int'(busy), 0);

    run(1'b0, 24 + $urandom_range(0, 7), 1'b1);          // async reset mid-note
    run(1'b0, 0, 1'b0);                                  // replay from entry 0

    for (int r = 0; r < 6; r++)
      run(1'b1 & $urandom_range(0, 1), $urandom_range(1, 400), ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    run(1'b0, 0, 1'b0);

    repeat (4) @(posedge clk);
    #1 check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/melody_seq.md
MELODY_SEQ -- requirements
Module: melody_seq

Interface
REQ-001 Parameter TICK_DIV, default 1000, clk cycles per time tick (1 ms at 1 MHz clk).
REQ-002 Parameter UNIT_TICKS, default 125, ticks per duration unit.
REQ-003 Parameter GAP_TICKS, default 20, silent ticks closing every note; SHALL be < UNIT_TICKS.
REQ-004 Port clk, input, 1, system clock, 1 MHz nominal.
REQ-005 Port reset, input, 1, asynchronous, active-high reset.
REQ-006 Port start, input, 1, request to begin the song; sampled each rising clk edge.
REQ-007 Port stop, input, 1, abort playback.
REQ-008 Port loop, input, 1, when 1, restart at entry 0 after the end marker instead of finishing.
REQ-009 Port half_period, output, 12, half-period count for the downstream tone divider; that divider toggles after half_period+1 cycles.
REQ-010 Port tone_en, output, 1, downstream tone enable; 0 means silence.
REQ-011 Port note_idx, output, 4, index of the current song entry.
REQ-012 Port busy, output, 1, high in PLAY and GAP.
REQ-013 Port done, output, 1, one-cycle pulse at natural song end.

Function
REQ-014 The note table SHALL map codes 1..13 to half_period values 1911,1804,1703,1607,1517,1432,1351,1275,1204,1136,1072,1012,955 (C4..C5).
REQ-015 Codes 0 and 14 SHALL be rests: tone_en=0, half_period=0. Code 15 SHALL be the end marker.
REQ-016 The song ROM SHALL hold 16 entries, each {note[3:0], dur[2:0]}; length = dur+1 units.
REQ-017 ROM content SHALL be entries 0..14 = (1,0)(1,0)(8,0)(8,0)(10,0)(10,0)(8,1)(6,0)(6,0)(5,0)(5,0)(3,0)(3,0)(1,1)(15,0); entry 15 SHALL be (15,0).
REQ-018 The FSM SHALL have states IDLE, PLAY, GAP and DONE.
REQ-019 IDLE with start=1 and stop=0 SHALL go to PLAY on the next edge, with note_idx=0, the tick prescaler cleared and the tick counter cleared.
REQ-020 In PLAY, tone_en SHALL be 1 for non-rest codes, and half_period SHALL equal the table value of ROM[note_idx].
REQ-021 PLAY SHALL last exactly ((dur+1)*UNIT_TICKS - GAP_TICKS)*TICK_DIV cycles, then enter GAP.
REQ-022 GAP SHALL last exactly GAP_TICKS*TICK_DIV cycles, with tone_en=0 and half_period held.
REQ-023 At GAP exit, note_idx SHALL increment.
REQ-024 At GAP exit, if the next entry is code 15 or note_idx would wrap 15->0, then: loop=1 -> PLAY with note_idx=0; loop=0 -> DONE.
REQ-025 When an entry is loaded with code 15 at note_idx 0, the FSM SHALL go to DONE.
REQ-026 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-027 The prescaler and tick counter SHALL restart at each PLAY and GAP entry, so no partial tick carries over.
REQ-028 stop=1 in any state SHALL force IDLE on the next edge, with tone_en=0, busy=0, half_period=0, note_idx=0, and no done pulse.
REQ-029 If start and stop are both 1 in the same cycle, stop SHALL win.
REQ-030 start while busy SHALL be ignored.
REQ-031 The loop input SHALL be sampled only at end-of-song evaluation.
REQ-032 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-033 While reset=1, asynchronously: state=IDLE, half_period=0, tone_en=0, note_idx=0, busy=0, done=0, counters=0.
REQ-034 Reset asserted mid-note SHALL silence tone_en immediately, without waiting for clk.
REQ-035 After reset deassertion, the block SHALL remain IDLE until start.

Verification (TICK_DIV=4, UNIT_TICKS=3, GAP_TICKS=1)
REQ-036 Scenario: start pulse -> next edge busy=1, tone_en=1, half_period=1911, note_idx=0; tone_en=1 for 8 cycles, then 0 for 4 cycles; then note_idx=1, tone_en=1.
REQ-037 Scenario: entry 6 (dur=1) -> tone_en high for 20 cycles, gap 4 cycles, half_period=1275.
REQ-038 Scenario: full song, loop=0 -> after entry 13 gap, done=1 for exactly one cycle, then busy=0, tone_en=0, note_idx=0; total 12*12+2*24 = 192 cycles from first PLAY cycle to DONE.
REQ-039 Scenario: full song, loop=1 -> after entry 13 gap, note_idx=0, half_period=1911, no done pulse.
REQ-040 Scenario: stop asserted during PLAY of entry 4 -> next edge IDLE, tone_en=0, half_period=0, done stays 0; start together with stop -> remains IDLE.
REQ-041 Scenario: reset pulsed asynchronously between clk edges during PLAY -> tone_en=0 and busy=0 before the next clk edge; start after release -> replay from entry 0.
